uart_rx_core: RTL

//   Serial receive front-end of the APB UART: samples the RsRx line at 16x the bit rate and deframes 8N1 characters.

---
 rtl/uart_rx_core_pkg.sv | 17 +
 rtl/uart_rx_core_baud_gen.sv | 32 +++
 rtl/uart_rx_core.sv | 129 ++++++++++++
 3 files changed

// File: rtl/uart_rx_core_pkg.sv
// Shared UART definitions: receiver FSM states and
// oversampling constants, also used by the TX side.
package uart_rx_core_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  localparam int OVERSAMPLE = 16;
  localparam logic [3:0] MID_SAMPLE = 4'd7;
  localparam logic [3:0] LAST_SAMPLE =
    4'(OVERSAMPLE - 1);

endpackage

// File: rtl/uart_rx_core_baud_gen.sv
// Oversample tick generator: one registered tick
// every prescale+1 cycles, held cleared by clr.
module uart_baud_gen #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] cnt;

  // >= so a lowered prescale wraps on the next cycle
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt >= prescale) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART 8N1 receive front-end: synchronises RsRx,
// deframes characters and strobes the RX FIFO.
module uart_rx_core
  import uart_rx_core_pkg::*;
#(
  parameter int PRESCALE_W = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  rx_in,
  input  logic                  fifo_full,
  output logic [DATA_BITS-1:0]  rx_data,
  output logic                  rx_wr,
  output logic                  frame_err,
  output logic                  overrun_err,
  output logic                  busy
);

  localparam int BW = $clog2(DATA_BITS + 1);

  logic                 sync1;
  logic                 rx_s;
  logic                 rx_prev;
  logic                 tick;
  logic                 fall;
  logic                 mid_start;
  logic                 mid_bit;
  logic                 last_bit;
  logic                 wr_d;
  logic                 ferr_d;
  logic                 ovr_d;
  logic [3:0]           scnt;
  logic [BW-1:0]        bidx;
  logic [DATA_BITS-1:0] shreg;
  state_t               state;
  state_t               state_nxt;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      sync1   <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= rx_in;
      rx_s    <= sync1;
      rx_prev <= rx_s;
    end
  end

  uart_baud_gen #(
    .PRESCALE_W (PRESCALE_W)
  ) u_baud (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .clr      (!en || state == IDLE),
    .prescale (prescale),
    .tick     (tick)
  );

  assign fall      = rx_prev & ~rx_s;
  assign mid_start = tick && scnt == MID_SAMPLE;
  assign mid_bit   = tick && scnt == LAST_SAMPLE;
  assign last_bit  = bidx == BW'(DATA_BITS - 1);
  assign busy      = state != IDLE;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!en) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:  if (fall) state_nxt = START;
        START: if (mid_start)
                 state_nxt = rx_s ? IDLE : DATA;
        DATA:  if (mid_bit && last_bit)
                 state_nxt = STOP;
        STOP:  if (mid_bit) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    wr_d   = 1'b0;
    ferr_d = 1'b0;
    ovr_d  = 1'b0;
    if (en && state == STOP && mid_bit) begin
      wr_d   = rx_s && !fifo_full;
      ovr_d  = rx_s && fifo_full;
      ferr_d = !rx_s;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      scnt        <= '0;
      bidx        <= '0;
      shreg       <= '0;
      rx_data     <= '0;
      rx_wr       <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      rx_wr       <= wr_d;
      frame_err   <= ferr_d;
      overrun_err <= ovr_d;
      if (wr_d) rx_data <= shreg;
      if (state == IDLE || state_nxt != state)
        scnt <= '0;
      else if (tick)
        scnt <= scnt + 4'd1;
      if (state != DATA)
        bidx <= '0;
      else if (mid_bit)
        bidx <= bidx + 1'b1;
      if (en && state == DATA && mid_bit)
        shreg <= {rx_s, shreg[DATA_BITS-1:1]};
    end
  end

endmodule
